// File: rtl/cpu_control_fsm.sv
// Moore control FSM for the 16-bit RISC datapath: fetch, decode, execute and
// writeback sequencing. Every output depends only on the current state.
module cpu_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);
  localparam logic [2:0] NS_RN = 3'b001, NS_RD = 3'b010, NS_RM = 3'b100;
  localparam logic [1:0] MEM_READ = 2'b01, MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    RST, IF1, IF2, UPDATE_PC, DECODE, WRITE_IMM, GET_A, GET_B, GET_B_RD,
    ALU, MOVSH, CMP, WRITE_RD, ADDR, LOAD_ADDR, MEM_RD, WB_MEM, STR_C,
    MEM_WR, HALT
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= RST;
    else       state <= state_next;
  end

  // GET_B is shared by MOV-reg and the ALU ops; IR holds the opcode steady
  // for the whole instruction, so later states can re-inspect it.
  always_comb begin
    state_next = state;
    case (state)
      RST:       state_next = IF1;
      IF1:       state_next = IF2;
      IF2:       state_next = UPDATE_PC;
      UPDATE_PC: state_next = DECODE;
      DECODE: begin
        case ({opcode, op})
          5'b110_10: state_next = WRITE_IMM;
          5'b110_00: state_next = GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: state_next = GET_A;
          5'b101_11: state_next = GET_B;
          5'b011_00, 5'b100_00: state_next = GET_A;
          default:   state_next = HALT;
        endcase
      end
      WRITE_IMM: state_next = IF1;
      GET_A:     state_next = (opcode == 3'b101) ? GET_B : ADDR;
      GET_B: begin
        if (opcode == 3'b110)            state_next = MOVSH;
        else if ({opcode, op} == 5'b101_01) state_next = CMP;
        else                             state_next = ALU;
      end
      ALU, MOVSH: state_next = WRITE_RD;
      CMP:        state_next = IF1;
      WRITE_RD:   state_next = IF1;
      ADDR:       state_next = LOAD_ADDR;
      LOAD_ADDR:  state_next = (opcode == 3'b100) ? GET_B_RD : MEM_RD;
      MEM_RD:     state_next = WB_MEM;
      WB_MEM:     state_next = IF1;
      GET_B_RD:   state_next = STR_C;
      STR_C:      state_next = MEM_WR;
      MEM_WR:     state_next = IF1;
      HALT:       state_next = HALT;
      default:    state_next = HALT;
    endcase
  end

  always_comb begin
    nsel      = 3'b000;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    halted    = 1'b0;
    case (state)
      RST:       begin reset_pc = 1'b1; load_pc = 1'b1; end
      IF1:       begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
      IF2:       begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
      UPDATE_PC: load_pc = 1'b1;
      WRITE_IMM: begin nsel = NS_RN; vsel = 2'b10; write = 1'b1; end
      GET_A:     begin nsel = NS_RN; loada = 1'b1; end
      GET_B:     begin nsel = NS_RM; loadb = 1'b1; end
      GET_B_RD:  begin nsel = NS_RD; loadb = 1'b1; end
      ALU:       loadc = 1'b1;
      MOVSH:     begin asel = 1'b1; loadc = 1'b1; end
      CMP:       loads = 1'b1;
      WRITE_RD:  begin nsel = NS_RD; write = 1'b1; end
      ADDR:      begin bsel = 1'b1; loadc = 1'b1; end
      LOAD_ADDR: load_addr = 1'b1;
      MEM_RD:    mem_cmd = MEM_READ;
      // Read data arrives one cycle late, so READ is held while writing back.
      WB_MEM:    begin mem_cmd = MEM_READ; nsel = NS_RD; vsel = 2'b11; write = 1'b1; end
      STR_C:     begin asel = 1'b1; loadc = 1'b1; end
      MEM_WR:    mem_cmd = MEM_WRITE;
      HALT:      halted = 1'b1;
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench for cpu_control_fsm: a step-sequence model predicts every
// output vector each cycle; directed literals pin periods, reset and HALT.
module tb_cpu_control_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write, load_ir;
  logic       load_pc, reset_pc, addr_sel, load_addr, halted;
  logic [1:0] vsel, mem_cmd;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .nsel(nsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel),
    .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] nsel;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic       write, load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } ov_t;

  ov_t dv;
  assign dv = {nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write,
               load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

  typedef enum int {
    M_RST, M_IF1, M_IF2, M_UPD, M_DEC, M_WIMM, M_GETA, M_GETB, M_GETBRD,
    M_ALU, M_MOVSH, M_CMP, M_WRD, M_ADDR, M_LADDR, M_MEMRD, M_WBMEM,
    M_STRC, M_MEMWR, M_HALT
  } step_t;
  typedef step_t sq_t[$];

  // Execute-phase step list for each instruction encoding.
  function automatic sq_t program_of(logic [2:0] o, logic [1:0] p);
    case ({o, p})
      5'b110_10: return '{M_WIMM};
      5'b110_00: return '{M_GETB, M_MOVSH, M_WRD};
      5'b101_00, 5'b101_10: return '{M_GETA, M_GETB, M_ALU, M_WRD};
      5'b101_01: return '{M_GETA, M_GETB, M_CMP};
      5'b101_11: return '{M_GETB, M_ALU, M_WRD};
      5'b011_00: return '{M_GETA, M_ADDR, M_LADDR, M_MEMRD, M_WBMEM};
      5'b100_00: return '{M_GETA, M_ADDR, M_LADDR, M_GETBRD, M_STRC, M_MEMWR};
      default:   return '{M_HALT};
    endcase
  endfunction

  function automatic ov_t exp_vec(step_t s);
    ov_t v;
    v = '0;
    case (s)
      M_RST:    begin v.reset_pc = 1; v.load_pc = 1; end
      M_IF1:    begin v.addr_sel = 1; v.mem_cmd = 2'b01; end
      M_IF2:    begin v.addr_sel = 1; v.mem_cmd = 2'b01; v.load_ir = 1; end
      M_UPD:    v.load_pc = 1;
      M_WIMM:   begin v.nsel = 3'b001; v.vsel = 2'b10; v.write = 1; end
      M_GETA:   begin v.nsel = 3'b001; v.loada = 1; end
      M_GETB:   begin v.nsel = 3'b100; v.loadb = 1; end
      M_GETBRD: begin v.nsel = 3'b010; v.loadb = 1; end
      M_ALU:    v.loadc = 1;
      M_MOVSH:  begin v.asel = 1; v.loadc = 1; end
      M_CMP:    v.loads = 1;
      M_WRD:    begin v.nsel = 3'b010; v.write = 1; end
      M_ADDR:   begin v.bsel = 1; v.loadc = 1; end
      M_LADDR:  v.load_addr = 1;
      M_MEMRD:  v.mem_cmd = 2'b01;
      M_WBMEM:  begin v.mem_cmd = 2'b01; v.nsel = 3'b010; v.vsel = 2'b11; v.write = 1; end
      M_STRC:   begin v.asel = 1; v.loadc = 1; end
      M_MEMWR:  v.mem_cmd = 2'b10;
      M_HALT:   v.halted = 1;
      default:  ;
    endcase
    return v;
  endfunction

  step_t m_cur = M_RST;
  step_t m_rest[$];
  bit    mvalid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cur  = M_RST;
      m_rest = '{M_IF1, M_IF2, M_UPD, M_DEC};
      mvalid = 1'b1;
    end else if (mvalid && m_cur != M_HALT) begin
      if (m_cur == M_DEC) m_rest = program_of(opcode, op);
      if (m_rest.size() == 0) m_rest = '{M_IF1, M_IF2, M_UPD, M_DEC};
      m_cur = m_rest.pop_front();
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the full output vector.
  task automatic tick();
    ov_t e;
    @(negedge clk);
    if (mvalid) begin
      e = exp_vec(m_cur);
      checks++;
      if (dv !== e) begin
        errors++;
        $display("FAIL outputs step=%s: got %05h expected %05h at %0t",
                 m_cur.name(), dv, e, $time);
      end
    end
  endtask

  task automatic goto_if1();
    int n = 0;
    while (m_cur != M_IF1 && n < 40) begin tick(); n++; end
    chk("reach_if1", {31'd0, m_cur == M_IF1}, 32'd1);
  endtask

  task automatic run_instr(logic [2:0] o, logic [1:0] p, int exp_period);
    int n = 0;
    goto_if1();
    opcode = o; op = p;
    do begin tick(); n++; end while (m_cur != M_IF1 && n < 40);
    chk($sformatf("period_%b_%b", o, p), n, exp_period);
  endtask

  task automatic halt_test(logic [2:0] o, logic [1:0] p);
    int n = 0;
    goto_if1();
    opcode = o; op = p;
    do begin tick(); n++; end while (!halted && n < 10);
    chk("halt_latency", n, 4);
    repeat (20) begin
      tick();
      chk("halt_hold", dv, 32'h1);
    end
    reset = 1'b1;
    tick();
    chk("halt_reset", {write, reset_pc, load_pc, halted}, 4'b0110);
    reset = 1'b0;
  endtask

  logic [4:0] leg_enc[8] = '{5'b110_10, 5'b110_00, 5'b101_11, 5'b101_01,
                             5'b101_00, 5'b101_10, 5'b011_00, 5'b100_00};
  int         leg_per[8] = '{5, 7, 7, 7, 8, 8, 9, 10};

  initial begin
    logic [4:0] enc;
    int n;
    reset = 1'b1; opcode = 3'b110; op = 2'b10;
    tick(); tick();
    chk("rst_pc", {reset_pc, load_pc, write, load_ir, mem_cmd}, 6'b110000);
    reset = 1'b0;
    tick(); chk("if1", {addr_sel, mem_cmd, load_ir}, 4'b1010);
    tick(); chk("if2", {addr_sel, mem_cmd, load_ir}, 4'b1011);
    tick(); chk("update_pc", {load_pc, reset_pc}, 2'b10);
    tick(); chk("decode_quiet", dv, 32'h0);
    tick(); chk("write_imm", {nsel, vsel, write}, {3'b001, 2'b10, 1'b1});
    tick(); chk("back_to_if1", {addr_sel, mem_cmd, load_ir}, 4'b1010);

    for (int i = 0; i < 8; i++) begin
      enc = leg_enc[i];
      run_instr(enc[4:2], enc[1:0], leg_per[i]);
    end

    // Abort an ADD in its ALU step.
    goto_if1();
    opcode = 3'b101; op = 2'b00;
    n = 0;
    do begin tick(); n++; end while (m_cur != M_ALU && n < 20);
    chk("add_alu_loadc", {loadc, write}, 2'b10);
    reset = 1'b1;
    tick(); chk("abort_rst", {write, reset_pc, load_pc}, 3'b011);
    reset = 1'b0;
    tick(); chk("abort_if1", {addr_sel, mem_cmd, write}, 4'b1010);

    halt_test(3'b111, 2'b01);
    halt_test(3'b000, 2'b00);

    for (int i = 0; i < 120; i++) begin
      int sel = $urandom_range(0, 9);
      goto_if1();
      if (sel < 7) begin
        int k = $urandom_range(0, 7);
        enc = leg_enc[k];
        if ($urandom_range(0, 5) == 0) begin
          opcode = enc[4:2]; op = enc[1:0];
          repeat ($urandom_range(1, 8)) tick();
          reset = 1'b1; tick(); reset = 1'b0;
        end else begin
          run_instr(enc[4:2], enc[1:0], leg_per[k]);
        end
      end else begin
        enc = 5'($urandom);
        opcode = enc[4:2]; op = enc[1:0];
        repeat ($urandom_range(4, 12)) tick();
        reset = 1'b1; tick(); reset = 1'b0;
      end
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
